// File: rtl/interboard_output.sv
// interboard_output: transmit end of the board-to-board link.
// Drains the local outbound FIFO (11-bit words) and forwards them to the
// neighbouring board. It honours the neighbour's synchronised flow-control
// line, limits bursts to MAX_BURST reads and then inserts a GAP_CYCLES idle
// gap. It also keeps a wrapping count of the words it has sent.
//
// Ports:
//   transmit_clk  block clock, also forwarded to the neighbour as its rx clock
//   reset         synchronous, active-low reset
//   remote_read   neighbour flow control, 1 = may send (asynchronous to us)
//   fifo_empty    outbound FIFO empty flag
//   fifo_q        outbound FIFO data, valid one cycle after fifo_rdreq
//   fifo_rdreq    FIFO read request (combinational)
//   data, valid   word and qualifier to the neighbour (registered)
//   words_sent    wrapping count of words sent with valid=1
//   stalled       FIFO has data but the neighbour is blocking us
module interboard_output #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_BURST   = 16,
  parameter int GAP_CYCLES  = 2
) (
  input  logic        transmit_clk,
  input  logic        reset,
  input  logic        remote_read,
  input  logic        fifo_empty,
  input  logic [10:0] fifo_q,
  output logic        fifo_rdreq,
  output logic [10:0] data,
  output logic        valid,
  output logic [31:0] words_sent,
  output logic        stalled
);

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  state_t                   state_r;
  state_t                   state_s;
  logic [7:0]               burst_cnt_r;
  logic [7:0]               burst_cnt_s;
  logic [7:0]               gap_cnt_r;
  logic [7:0]               gap_cnt_s;
  logic [SYNC_STAGES-1:0]   sync_r;
  logic                     remote_sync_s;
  logic                     can_read_s;
  logic                     rdreq_s;
  logic                     rd_d_r;
  logic                     valid_r;
  logic [10:0]              data_r;
  logic [31:0]              words_sent_r;
  logic                     stalled_r;

  assign remote_sync_s = sync_r[SYNC_STAGES-1];
  // Gating with reset keeps the FIFO untouched while reset is held low,
  // even before the state register has been cleared.
  assign can_read_s    = reset & remote_sync_s & ~fifo_empty;

  assign fifo_rdreq = rdreq_s;
  assign data       = data_r;
  assign valid      = valid_r;
  assign words_sent = words_sent_r;
  assign stalled    = stalled_r;

  // Synchroniser chain for the neighbour's flow-control line.
  always_ff @(posedge transmit_clk) begin
    if (!reset) begin
      sync_r <= '0;
    end else begin
      sync_r[0] <= remote_read;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // FSM state and burst/gap counters.
  always_ff @(posedge transmit_clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      burst_cnt_r <= 8'd0;
      gap_cnt_r   <= 8'd0;
    end else begin
      state_r     <= state_s;
      burst_cnt_r <= burst_cnt_s;
      gap_cnt_r   <= gap_cnt_s;
    end
  end

  // Next-state, counter updates and the FIFO read request.
  always_comb begin
    state_s     = state_r;
    burst_cnt_s = burst_cnt_r;
    gap_cnt_s   = gap_cnt_r;
    rdreq_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (can_read_s) begin
          state_s = ST_STREAM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        rdreq_s = can_read_s;
        if (can_read_s && (burst_cnt_r == BURST_LAST)) begin
          burst_cnt_s = 8'd0;
          if (GAP_CYCLES > 0) begin
            state_s = ST_GAP;
          end else begin
            state_s = ST_STREAM;
          end
        end else if (!can_read_s) begin
          // Any interruption restarts the burst from zero.
          burst_cnt_s = 8'd0;
          state_s     = ST_IDLE;
        end else begin
          burst_cnt_s = burst_cnt_r + 8'd1;
        end
      end
      ST_GAP: begin
        // Flow control and FIFO state are deliberately ignored here so the
        // gap always runs to completion.
        if (gap_cnt_r == GAP_LAST) begin
          gap_cnt_s = 8'd0;
          state_s   = ST_IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r + 8'd1;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        burst_cnt_s = 8'd0;
        gap_cnt_s   = 8'd0;
      end
    endcase
  end

  // Output datapath: read request -> FIFO data -> registered data/valid.
  always_ff @(posedge transmit_clk) begin
    if (!reset) begin
      rd_d_r       <= 1'b0;
      valid_r      <= 1'b0;
      data_r       <= 11'd0;
      words_sent_r <= 32'd0;
      stalled_r    <= 1'b0;
    end else begin
      rd_d_r       <= rdreq_s;
      valid_r      <= rd_d_r;
      if (rd_d_r) begin
        data_r <= fifo_q;
      end else begin
        data_r <= data_r;
      end
      words_sent_r <= words_sent_r + {31'd0, valid_r};
      stalled_r    <= ~fifo_empty & ~remote_sync_s;
    end
  end

endmodule
